// File: rtl/ahbl_apb_bridge.sv
// rtl/ahbl_apb_bridge.sv - AHB-Lite slave to APB3 master bridge
//
// Purpose: converts each accepted AHB-Lite transfer into exactly one APB
// SETUP/ACCESS cycle. Only one transfer is in flight at a time. PREADY wait
// states stretch HREADYOUT. PSLVERR, an unmapped slot or a PREADY timeout
// produce a two-cycle AHB ERROR response. Every output is a flop.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL/HADDR/HTRANS/    AHB-Lite address phase
//   HWRITE/HSIZE/HREADY
//   HWDATA                AHB write data (data phase)
//   HREADYOUT/HRESP/      AHB response and read data
//   HRDATA
//   PADDR/PSEL/PENABLE/   APB3 request
//   PWRITE/PWDATA
//   PRDATA/PREADY/PSLVERR APB3 completion
module ahbl_apb_bridge #(
  parameter int APB_AW    = 12,
  parameter int NUM_SLOTS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic [APB_AW-1:0]    PADDR,
  output logic [NUM_SLOTS-1:0] PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WLAT, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_e;

  localparam logic [4:0]  NS5  = 5'(NUM_SLOTS);
  localparam logic [15:0] TO16 = 16'(TIMEOUT);

  state_e                 state_q, state_d;
  logic                   hreadyout_q, hreadyout_d;
  logic                   hresp_q, hresp_d;
  logic [31:0]            hrdata_q, hrdata_d;
  logic [APB_AW-1:0]      paddr_q, paddr_d;
  logic [NUM_SLOTS-1:0]   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic [3:0]             slot_q, slot_d;
  logic [2:0]             hsize_q, hsize_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   accept;
  logic [3:0]             addr_slot;
  logic                   slot_ok;
  logic [15:0]            cnt_inc;
  logic                   timeout_hit;
  logic [NUM_SLOTS-1:0]   slot_onehot;

  assign addr_slot = HADDR[APB_AW+3:APB_AW];
  assign slot_ok   = ({1'b0, addr_slot} < NS5);
  assign accept    = HSEL & HREADY & HTRANS[1] & hreadyout_q &
                     ((state_q == S_IDLE) || (state_q == S_DONE));

  // Saturating increment; the compare sees the count including this cycle,
  // so ERROR follows exactly TIMEOUT ACCESS cycles with PREADY low.
  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout_hit = !PREADY && (cnt_inc >= TO16);

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (!accept)       state_d = S_IDLE;
        else if (!slot_ok) state_d = S_ERR1;
        else if (HWRITE)   state_d = S_WLAT;
        else               state_d = S_SETUP;
      end
      S_WLAT:   state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY)           state_d = PSLVERR ? S_ERR1 : S_DONE;
        else if (timeout_hit) state_d = S_ERR1;
      end
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; decoded from state_d so the flops line up
  // with the state they describe.
  always_comb begin
    slot_d  = accept ? addr_slot : slot_q;
    paddr_d = accept ? HADDR[APB_AW-1:0] : paddr_q;
    pwrite_d = accept ? HWRITE : pwrite_q;
    hsize_d = accept ? HSIZE : hsize_q;

    slot_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_onehot[i] = (slot_d == 4'(i));
    end

    hreadyout_d = !(state_d inside {S_WLAT, S_SETUP, S_ACCESS, S_ERR1});
    hresp_d     = (state_d inside {S_ERR1, S_ERR2});
    psel_d      = (state_d inside {S_SETUP, S_ACCESS}) ? slot_onehot : '0;
    penable_d   = (state_d == S_ACCESS);

    // HWDATA is valid in the data phase, which is the WLAT cycle.
    pwdata_d = (state_q == S_WLAT) ? HWDATA : pwdata_q;

    hrdata_d = hrdata_q;
    if ((state_q == S_ACCESS) && PREADY && !PSLVERR && !pwrite_q) begin
      hrdata_d = PRDATA;
    end

    cnt_d = cnt_q;
    if (state_q == S_SETUP)                  cnt_d = '0;
    else if ((state_q == S_ACCESS) && !PREADY) cnt_d = cnt_inc;
  end

  // Output and datapath registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      slot_q      <= '0;
      hsize_q     <= '0;
      cnt_q       <= '0;
    end else begin
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      slot_q      <= slot_d;
      hsize_q     <= hsize_d;
      cnt_q       <= cnt_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// tb/tb_ahbl_apb_bridge.sv - scoreboard bench for ahbl_apb_bridge
module tb_ahbl_apb_bridge;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET, hsel1, hsel2, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA, PRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        PREADY, PSLVERR;

  logic        hro1, hresp1, pen1, pwr1;
  logic [31:0] hrdata1, pwd1;
  logic [11:0] paddr1;
  logic [15:0] psel1;

  logic        hro2, hresp2, pen2, pwr2;
  logic [31:0] hrdata2, pwd2;
  logic [11:0] paddr2;
  logic [3:0]  psel2;

  ahbl_apb_bridge dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(hro1), .HRDATA(hrdata1), .HRESP(hresp1), .PADDR(paddr1),
    .PSEL(psel1), .PENABLE(pen1), .PWRITE(pwr1), .PWDATA(pwd1),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  ahbl_apb_bridge #(.APB_AW(12), .NUM_SLOTS(4), .TIMEOUT(3)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(hro2), .HRDATA(hrdata2), .HRESP(hresp2), .PADDR(paddr2),
    .PSEL(psel2), .PENABLE(pen2), .PWRITE(pwr2), .PWDATA(pwd2),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  logic use2 = 1'b0;
  wire        o_hro   = use2 ? hro2 : hro1;
  wire        o_hresp = use2 ? hresp2 : hresp1;
  wire        o_pen   = use2 ? pen2 : pen1;
  wire        o_pwr   = use2 ? pwr2 : pwr1;
  wire [31:0] o_hrd   = use2 ? hrdata2 : hrdata1;
  wire [31:0] o_pwd   = use2 ? pwd2 : pwd1;
  wire [11:0] o_paddr = use2 ? paddr2 : paddr1;
  wire [15:0] o_psel  = use2 ? {12'h000, psel2} : psel1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          waits;
    int          setups;
    int          accs;
    logic        resp;
    logic [31:0] rdata;
    logic [15:0] psel;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] exp_rd1 = '0;
  logic [31:0] exp_rd2 = '0;

  task automatic idle_cycle();
    hsel1 = 1'b0; hsel2 = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
  endtask

  // Entered and left at a negedge; the next call drives its address phase
  // in the completion cycle, giving back-to-back transfers.
  task automatic xfer(input string tag, input logic d2, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int lat, input logic [31:0] rd, input logic err);
    exp_t e, g;
    int ns, tmo, slot, pre;
    int waits = 0, setups = 0, accs = 0;
    logic done = 1'b0, err1_seen = 1'b0, pwr_s = 1'b0;
    logic [15:0] psel_s = '0;
    logic [11:0] paddr_s = '0;
    logic [31:0] pwd_s = '0;

    use2 = d2;
    ns   = d2 ? 4 : 16;
    tmo  = d2 ? 3 : 255;
    slot = int'(addr[15:12]);
    pre  = wr ? 2 : 1;
    e.tag = tag; e.paddr = addr[11:0]; e.pwrite = wr; e.pwdata = wdata;
    e.rdata = d2 ? exp_rd2 : exp_rd1;
    if (slot >= ns) begin
      e.setups = 0; e.accs = 0; e.psel = '0; e.resp = 1'b1; e.waits = 1;
    end else begin
      e.setups = 1;
      e.psel   = 16'(1) << slot;
      if (lat >= tmo) begin
        e.accs = tmo; e.resp = 1'b1; e.waits = pre + tmo + 1;
      end else if (err) begin
        e.accs = lat + 1; e.resp = 1'b1; e.waits = pre + lat + 2;
      end else begin
        e.accs = lat + 1; e.resp = 1'b0; e.waits = pre + lat + 1;
        if (!wr) e.rdata = rd;
      end
    end
    if (d2) exp_rd2 = e.rdata; else exp_rd1 = e.rdata;
    sbq.push_back(e);

    hsel1 = !d2; hsel2 = d2; HADDR = addr; HWRITE = wr; HTRANS = 2'b10;
    HSIZE = 3'b010;
    @(posedge HCLK);
    @(negedge HCLK);
    hsel1 = 1'b0; hsel2 = 1'b0; HTRANS = 2'b00; HWDATA = wdata;

    for (int i = 0; i < 300; i++) begin
      if (o_hro) begin
        done = 1'b1;
        break;
      end
      waits++;
      if (o_hresp) err1_seen = 1'b1;
      if (o_psel != 0 && !o_pen) begin
        setups++; psel_s = o_psel; paddr_s = o_paddr; pwr_s = o_pwr; pwd_s = o_pwd;
      end
      if (o_pen) begin
        accs++;
        PREADY  = (accs > lat);
        PSLVERR = err && (accs > lat);
        PRDATA  = rd;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
      @(negedge HCLK);
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    g = sbq.pop_front();
    chk({g.tag, "_done"}, 32'(done), 32'd1);
    chk({g.tag, "_waits"}, 32'(waits), 32'(g.waits));
    chk({g.tag, "_resp"}, 32'(o_hresp), 32'(g.resp));
    chk({g.tag, "_err1"}, 32'(err1_seen), 32'(g.resp));
    chk({g.tag, "_rdata"}, o_hrd, g.rdata);
    chk({g.tag, "_setups"}, 32'(setups), 32'(g.setups));
    chk({g.tag, "_accs"}, 32'(accs), 32'(g.accs));
    chk({g.tag, "_psel"}, 32'(psel_s), 32'(g.psel));
    if (g.setups != 0) begin
      chk({g.tag, "_paddr"}, 32'(paddr_s), 32'(g.paddr));
      chk({g.tag, "_pwrite"}, 32'(pwr_s), 32'(g.pwrite));
      if (g.pwrite) chk({g.tag, "_pwdata"}, pwd_s, g.pwdata);
    end
  endtask

  initial begin
    logic        w, er;
    logic [3:0]  s;
    int          l;
    logic        reached;

    HRESET = 1'b1; hsel1 = 1'b0; hsel2 = 1'b0; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'b000; HWDATA = '0; HREADY = 1'b1;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst_hro", 32'(hro1), 32'd1);
    chk("rst_hresp", 32'(hresp1), 32'd0);
    chk("rst_hrdata", hrdata1, 32'd0);
    chk("rst_psel", 32'(psel1), 32'd0);
    chk("rst_pen", 32'(pen1), 32'd0);
    chk("rst_pwr", 32'(pwr1), 32'd0);
    chk("rst_paddr", 32'(paddr1), 32'd0);
    chk("rst_pwdata", pwd1, 32'd0);
    chk("rst_hro2", 32'(hro2), 32'd1);
    chk("rst_psel2", 32'(psel2), 32'd0);
    HRESET = 1'b0;

    xfer("rd104",    0, 0, 32'h0000_0104, 32'h0,         0, 32'h0000_00A5, 0);
    xfer("wr3008",   0, 1, 32'h0000_3008, 32'hDEADBEEF,  0, 32'h0,         0);
    xfer("rd_wait5", 0, 0, 32'h0000_2010, 32'h0,         5, 32'h1234_5678, 0);
    xfer("rd_slverr",0, 0, 32'h0000_1020, 32'h0,         0, 32'hBAD0_BAD0, 1);
    idle_cycle();
    xfer("rd_post_err", 0, 0, 32'h0000_0040, 32'h0,      0, 32'h0BAD_F00D, 0);
    xfer("b2b_0",    0, 0, 32'h0000_0000, 32'h0,         0, 32'h1111_1111, 0);
    xfer("b2b_1",    0, 0, 32'h0000_1000, 32'h0,         0, 32'h2222_2222, 0);
    xfer("wr_slverr",0, 1, 32'h0000_4004, 32'h0000_CAFE, 1, 32'h0,         1);
    idle_cycle();
    xfer("wr_f000",  0, 1, 32'h0000_F000, 32'h5555_AAAA, 2, 32'h0,         0);

    xfer("unmapped", 1, 0, 32'h0000_5000, 32'h0,         0, 32'h0000_0077, 0);
    idle_cycle();
    xfer("timeout",  1, 0, 32'h0000_1004, 32'h0,        20, 32'h0000_0066, 0);
    idle_cycle();
    xfer("d2_rd",    1, 0, 32'h0000_2000, 32'h0,         2, 32'h0000_5A5A, 0);

    for (int k = 0; k < 6; k++) begin
      w  = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      l  = int'($urandom_range(0, 3));
      er = ($urandom_range(0, 3) == 0);
      xfer("rnd", 0, w, {16'h0, s, 12'($urandom)}, $urandom, l, $urandom, er);
      if (er) idle_cycle();
    end

    use2 = 1'b0;
    hsel1 = 1'b1; HADDR = 32'h0000_0100; HTRANS = 2'b01; HWRITE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin hsel1 = 1'b0; HTRANS = 2'b10; end
      @(negedge HCLK);
      chk("noact_hro", 32'(hro1), 32'd1);
      chk("noact_psel", 32'(psel1), 32'd0);
      chk("noact_hresp", 32'(hresp1), 32'd0);
    end

    hsel1 = 1'b1; HADDR = 32'h0000_1000; HTRANS = 2'b10; HWRITE = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    hsel1 = 1'b0; HTRANS = 2'b00; PREADY = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (pen1) begin reached = 1'b1; break; end
      @(negedge HCLK);
    end
    chk("rstmid_access", 32'(reached), 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rstmid_psel", 32'(psel1), 32'd0);
    chk("rstmid_pen", 32'(pen1), 32'd0);
    chk("rstmid_hro", 32'(hro1), 32'd1);
    chk("rstmid_hresp", 32'(hresp1), 32'd0);
    chk("rstmid_hrdata", hrdata1, 32'd0);
    HRESET = 1'b0;
    exp_rd1 = '0; exp_rd2 = '0;
    xfer("rd_post_rst", 0, 0, 32'h0000_2004, 32'h0, 1, 32'hFEED_0001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
